// File: rtl/mem_pkg.sv
// Shared constants, stage-2 payload type and misalignment rule for the MEM stage.
package mem_pkg;

    localparam int unsigned DEFAULT_ADDR_W = 15;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_B0   = 4'b0001;
    localparam logic [3:0] BE_HLO  = 4'b0011;
    localparam logic [3:0] BE_HHI  = 4'b1100;
    localparam logic [3:0] BE_W    = 4'b1111;

    typedef struct packed {
        logic       load;
        logic [2:0] funct3;
        logic [1:0] off;
        logic [4:0] rd;
        logic       mis;
    } s2_t;

    // Unknown funct3 encodings are reported as faults so they never touch memory.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic r;
        case (f3)
            F3_B, F3_BU: r = 1'b0;
            F3_H, F3_HU: r = off[0];
            F3_W:        r = (off != 2'b00);
            default:     r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/half lane from a read word and sign- or zero-extends it.
module lsu_load_align
    import mem_pkg::*;
(
    input  logic [31:0] i_r_data,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_off,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_r_data[7:0];
        case (i_off)
            2'd0: w_byte = i_r_data[7:0];
            2'd1: w_byte = i_r_data[15:8];
            2'd2: w_byte = i_r_data[23:16];
            2'd3: w_byte = i_r_data[31:24];
            default: w_byte = i_r_data[7:0];
        endcase
        w_half = i_off[1] ? i_r_data[31:16] : i_r_data[15:0];
    end

    always_comb begin
        o_data = '0;
        case (i_funct3)
            F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_data = {24'h000000, w_byte};
            F3_H:    o_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_data = {16'h0000, w_half};
            F3_W:    o_data = i_r_data;
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: issues loads/stores to word-addressed byte-enabled data memory
// and returns aligned load data (or a misalignment fault) to WB one cycle later.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W = mem_pkg::DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_load,
    input  logic              in_store,
    input  logic [2:0]        in_funct3,
    input  logic [31:0]       in_addr,
    input  logic [31:0]       in_wdata,
    input  logic [4:0]        in_rd,
    input  logic              stall,
    input  logic              flush,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_w_addr,
    output logic [31:0]       mem_w_data,
    output logic [ADDR_W-1:0] mem_r_addr,
    input  logic [31:0]       mem_r_data,
    output logic              out_valid,
    output logic [4:0]        out_rd,
    output logic [31:0]       out_data,
    output logic              out_misalign
);

    logic              w_accept;
    logic [ADDR_W-1:0] w_idx;
    logic [1:0]        w_off;
    logic              w_mis;
    logic [31:0]       w_aligned;
    logic              w_unused_addr;

    logic              r_s2_valid;
    s2_t               r_s2;
    logic [ADDR_W-1:0] r_held_addr;

    assign w_accept      = in_valid & (in_load | in_store) & ~stall & ~flush & ~rst;
    assign w_idx         = in_addr[ADDR_W+1:2];
    assign w_off         = in_addr[1:0];
    assign w_mis         = is_misaligned(in_funct3, w_off);
    // Address bits above the memory size wrap silently.
    assign w_unused_addr = &{1'b0, in_addr[31:ADDR_W+2]};

    // Store lane steering; write enables only for accepted, aligned stores.
    always_comb begin
        mem_we     = BE_NONE;
        mem_w_data = in_wdata;
        if (w_accept && in_store && !w_mis) begin
            case (in_funct3)
                F3_B: begin
                    mem_we     = BE_B0 << w_off;
                    mem_w_data = {4{in_wdata[7:0]}};
                end
                F3_H: begin
                    mem_we     = w_off[1] ? BE_HHI : BE_HLO;
                    mem_w_data = {2{in_wdata[15:0]}};
                end
                F3_W: begin
                    mem_we     = BE_W;
                    mem_w_data = in_wdata;
                end
                default: mem_we = BE_NONE;
            endcase
        end
    end

    assign mem_w_addr = w_idx;
    // Re-read the held word while stalled so mem_r_data stays stable for stage 2.
    assign mem_r_addr = stall ? r_held_addr : w_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid  <= 1'b0;
            r_s2        <= '0;
            r_held_addr <= '0;
        end else begin
            if (w_accept) begin
                r_held_addr <= w_idx;
            end
            if (flush) begin
                r_s2_valid <= 1'b0;
            end else if (!stall) begin
                r_s2_valid <= w_accept;
                if (w_accept) begin
                    r_s2.load   <= in_load;
                    r_s2.funct3 <= in_funct3;
                    r_s2.off    <= w_off;
                    r_s2.rd     <= in_rd;
                    r_s2.mis    <= w_mis;
                end
            end
        end
    end

    lsu_load_align u_align (
        .i_r_data (mem_r_data),
        .i_funct3 (r_s2.funct3),
        .i_off    (r_s2.off),
        .o_data   (w_aligned)
    );

    assign out_valid    = r_s2_valid;
    assign out_rd       = r_s2.rd;
    assign out_misalign = r_s2_valid & r_s2.mis;
    assign out_data     = (r_s2_valid && r_s2.load && !r_s2.mis) ? w_aligned : 32'h0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural byte-enabled data memory.
module tb_mem_access_unit;
    import mem_pkg::*;

    localparam int unsigned ADDR_W = 15;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_load;
    logic              in_store;
    logic [2:0]        in_funct3;
    logic [31:0]       in_addr;
    logic [31:0]       in_wdata;
    logic [4:0]        in_rd;
    logic              stall;
    logic              flush;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_w_addr;
    logic [31:0]       mem_w_data;
    logic [ADDR_W-1:0] mem_r_addr;
    logic [31:0]       mem_r_data;
    logic              out_valid;
    logic [4:0]        out_rd;
    logic [31:0]       out_data;
    logic              out_misalign;

    int total;
    int bad;

    logic [31:0] mem [0:1023];

    mem_access_unit #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_load      (in_load),
        .in_store     (in_store),
        .in_funct3    (in_funct3),
        .in_addr      (in_addr),
        .in_wdata     (in_wdata),
        .in_rd        (in_rd),
        .stall        (stall),
        .flush        (flush),
        .mem_we       (mem_we),
        .mem_w_addr   (mem_w_addr),
        .mem_w_data   (mem_w_data),
        .mem_r_addr   (mem_r_addr),
        .mem_r_data   (mem_r_data),
        .out_valid    (out_valid),
        .out_rd       (out_rd),
        .out_data     (out_data),
        .out_misalign (out_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: byte-enabled write and registered read on the same edge.
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_we[b]) mem[mem_w_addr[9:0]][8*b +: 8] <= mem_w_data[8*b +: 8];
        end
        mem_r_data <= mem[mem_r_addr[9:0]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [4:0] rd,
                           input logic [31:0] data, input logic mis);
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".rd"}, 32'(out_rd), 32'(rd));
        chk({tag, ".data"}, out_data, data);
        chk({tag, ".mis"}, 32'(out_misalign), 32'(mis));
    endtask

    task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
        in_valid  = 1'b1;
        in_load   = ld;
        in_store  = st;
        in_funct3 = f3;
        in_addr   = a;
        in_wdata  = wd;
        in_rd     = rd;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_load  = 1'b0;
        in_store = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        in_funct3 = F3_W;
        in_addr   = '0;
        in_wdata  = '0;
        in_rd     = '0;
        idle();
        tick();
        tick();

        // Reset blocks writes and clears held address and outputs
        drive(1'b0, 1'b1, F3_W, 32'h0000_0100, 32'hDEAD_BEEF, 5'd3);
        stall = 1'b1;
        #1;
        chk("rst_we", 32'(mem_we), 32'h0);
        chk("rst_held", 32'(mem_r_addr), 32'h0);
        stall = 1'b0;
        tick();
        chk_out("rst_out", 1'b0, 5'd0, 32'h0, 1'b0);
        rst = 1'b0;

        // SW then LW same word
        drive(1'b0, 1'b1, F3_W, 32'h0000_0100, 32'h1122_3344, 5'd0);
        #1;
        chk("sw_we", 32'(mem_we), 32'hF);
        chk("sw_waddr", 32'(mem_w_addr), 32'h40);
        chk("sw_wdata", mem_w_data, 32'h1122_3344);
        tick();
        chk_out("sw_ret", 1'b1, 5'd0, 32'h0, 1'b0);
        drive(1'b1, 1'b0, F3_W, 32'h0000_0100, 32'h0, 5'd5);
        #1;
        chk("lw_we", 32'(mem_we), 32'h0);
        chk("lw_raddr", 32'(mem_r_addr), 32'h40);
        tick();
        chk_out("lw", 1'b1, 5'd5, 32'h1122_3344, 1'b0);

        // Byte store and byte loads
        drive(1'b0, 1'b1, F3_B, 32'h0000_0103, 32'hABCD_EF80, 5'd0);
        #1;
        chk("sb_we", 32'(mem_we), 32'h8);
        chk("sb_wdata", mem_w_data, 32'h8080_8080);
        tick();
        drive(1'b1, 1'b0, F3_B, 32'h0000_0103, 32'h0, 5'd6);
        tick();
        chk_out("lb", 1'b1, 5'd6, 32'hFFFF_FF80, 1'b0);
        drive(1'b1, 1'b0, F3_BU, 32'h0000_0103, 32'h0, 5'd6);
        tick();
        chk_out("lbu", 1'b1, 5'd6, 32'h0000_0080, 1'b0);
        drive(1'b1, 1'b0, F3_BU, 32'h0000_0101, 32'h0, 5'd6);
        tick();
        chk_out("lbu1", 1'b1, 5'd6, 32'h0000_0033, 1'b0);

        // Half loads from 0x8001_7FFF
        drive(1'b0, 1'b1, F3_W, 32'h0000_0200, 32'h8001_7FFF, 5'd0);
        tick();
        drive(1'b1, 1'b0, F3_H, 32'h0000_0202, 32'h0, 5'd10);
        tick();
        chk_out("lh_hi", 1'b1, 5'd10, 32'hFFFF_8001, 1'b0);
        drive(1'b1, 1'b0, F3_HU, 32'h0000_0202, 32'h0, 5'd10);
        tick();
        chk_out("lhu_hi", 1'b1, 5'd10, 32'h0000_8001, 1'b0);
        drive(1'b1, 1'b0, F3_H, 32'h0000_0200, 32'h0, 5'd10);
        tick();
        chk_out("lh_lo", 1'b1, 5'd10, 32'h0000_7FFF, 1'b0);

        // Upper-half store
        drive(1'b0, 1'b1, F3_H, 32'h0000_0206, 32'h1234_BEEF, 5'd0);
        #1;
        chk("sh_we", 32'(mem_we), 32'hC);
        chk("sh_wdata", mem_w_data, 32'hBEEF_BEEF);
        tick();
        drive(1'b1, 1'b0, F3_HU, 32'h0000_0206, 32'h0, 5'd4);
        tick();
        chk_out("lhu_sh", 1'b1, 5'd4, 32'h0000_BEEF, 1'b0);

        // Misaligned accesses
        drive(1'b1, 1'b0, F3_W, 32'h0000_0102, 32'h0, 5'd7);
        #1;
        chk("mis_lw_we", 32'(mem_we), 32'h0);
        tick();
        chk_out("mis_lw", 1'b1, 5'd7, 32'h0, 1'b1);
        drive(1'b0, 1'b1, F3_H, 32'h0000_0101, 32'h0000_FFFF, 5'd0);
        #1;
        chk("mis_sh_we", 32'(mem_we), 32'h0);
        tick();
        chk_out("mis_sh", 1'b1, 5'd0, 32'h0, 1'b1);
        drive(1'b1, 1'b0, F3_W, 32'h0000_0100, 32'h0, 5'd5);
        tick();
        chk_out("mem_kept", 1'b1, 5'd5, 32'h8022_3344, 1'b0);
        drive(1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0, 5'd8);
        tick();
        chk_out("bad_f3", 1'b1, 5'd8, 32'h0, 1'b1);

        // Upper address bits wrap
        drive(1'b0, 1'b1, F3_W, 32'h8002_0104, 32'hCAFE_F00D, 5'd0);
        #1;
        chk("wrap_waddr", 32'(mem_w_addr), 32'h41);
        chk("wrap_we", 32'(mem_we), 32'hF);
        tick();
        chk_out("wrap_ret", 1'b1, 5'd0, 32'h0, 1'b0);
        drive(1'b1, 1'b0, F3_W, 32'h0000_0104, 32'h0, 5'd2);
        tick();
        chk_out("wrap_lw", 1'b1, 5'd2, 32'hCAFE_F00D, 1'b0);

        // Stall holds stage 2 and the read address
        drive(1'b1, 1'b0, F3_W, 32'h0000_0200, 32'h0, 5'd9);
        tick();
        chk_out("pre_stall", 1'b1, 5'd9, 32'h8001_7FFF, 1'b0);
        stall = 1'b1;
        drive(1'b0, 1'b1, F3_W, 32'h0000_0300, 32'h5A5A_5A5A, 5'd0);
        #1;
        chk("stall_we", 32'(mem_we), 32'h0);
        chk("stall_raddr", 32'(mem_r_addr), 32'h80);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("stall", 1'b1, 5'd9, 32'h8001_7FFF, 1'b0);
            chk("stall_we_n", 32'(mem_we), 32'h0);
            chk("stall_raddr_n", 32'(mem_r_addr), 32'h80);
        end
        stall = 1'b0;
        #1;
        chk("release_we", 32'(mem_we), 32'hF);
        chk("release_raddr", 32'(mem_r_addr), 32'hC0);
        tick();
        chk_out("release", 1'b1, 5'd0, 32'h0, 1'b0);
        drive(1'b1, 1'b0, F3_W, 32'h0000_0300, 32'h0, 5'd11);
        tick();
        chk_out("post_stall_lw", 1'b1, 5'd11, 32'h5A5A_5A5A, 1'b0);

        // Flush squashes a store
        flush = 1'b1;
        drive(1'b0, 1'b1, F3_W, 32'h0000_0300, 32'h1234_5678, 5'd0);
        #1;
        chk("flush_we", 32'(mem_we), 32'h0);
        tick();
        chk("flush_valid", 32'(out_valid), 32'h0);
        flush = 1'b0;
        drive(1'b1, 1'b0, F3_W, 32'h0000_0300, 32'h0, 5'd12);
        tick();
        chk_out("flush_kept", 1'b1, 5'd12, 32'h5A5A_5A5A, 1'b0);

        // Reset while a load is in stage 2
        rst = 1'b1;
        drive(1'b1, 1'b0, F3_W, 32'h0000_0200, 32'h0, 5'd13);
        #1;
        chk("rst2_we", 32'(mem_we), 32'h0);
        tick();
        chk_out("rst2_out", 1'b0, 5'd0, 32'h0, 1'b0);
        rst = 1'b0;
        idle();
        tick();
        chk_out("idle", 1'b0, 5'd0, 32'h0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
